// File: rtl/hazard_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hazard_pkg                                                           |
// | Shared types and constants for the pipeline hazard controller.       |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_e;

    typedef enum logic [0:0] {
        S_RUN  = 1'b0,
        S_WAIT = 1'b1
    } ctrl_state_e;

    // EX-stage shadow entry; MEM/WB keep only the fields they need.
    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       wren;
        logic       load;
        logic       lsu;
    } stage_slot_t;

    typedef struct packed {
        logic [4:0] rd;
        logic       wren;
        logic       lsu;
    } post_slot_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    function automatic fwd_sel_e fwd_pick(
        input logic [4:0] rs,
        input post_slot_t mem,
        input post_slot_t wb
    );
        if (mem.wren && (mem.rd == rs)) begin
            return FWD_MEM;
        end else if (wb.wren && (wb.rd == rs)) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hazard_scoreboard                                                    |
// | EX/MEM/WB destination shadow slots, forwarding and load-use compare. |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module hazard_scoreboard
    import hazard_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_id_inst,
    input  logic        i_id_rd_wren,
    input  logic        i_id_lsu_rden,
    input  logic        i_id_lsu_wren,
    input  logic        i_stall_ex,
    input  logic        i_bubble_ex,
    input  logic        i_stall_mem,
    input  logic        i_clear_mem,
    output logic        o_load_use,
    output logic        o_mem_lsu,
    output logic [1:0]  o_fwd_a_sel,
    output logic [1:0]  o_fwd_b_sel
);

    stage_slot_t r_ex_slot;
    post_slot_t  r_mem_slot;
    post_slot_t  r_wb_slot;
    stage_slot_t w_id_slot;
    post_slot_t  w_ex_post;
    logic        w_unused;

    always_comb begin
        w_id_slot      = '0;
        w_id_slot.rs1  = i_id_inst[19:15];
        w_id_slot.rs2  = i_id_inst[24:20];
        w_id_slot.rd   = i_id_inst[11:7];
        w_id_slot.wren = i_id_rd_wren && (i_id_inst[11:7] != 5'd0);
        w_id_slot.load = i_id_lsu_rden;
        w_id_slot.lsu  = i_id_lsu_rden || i_id_lsu_wren;
    end

    assign w_ex_post = '{rd: r_ex_slot.rd, wren: r_ex_slot.wren, lsu: r_ex_slot.lsu};

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_ex_slot  <= '0;
            r_mem_slot <= '0;
            r_wb_slot  <= '0;
        end else begin
            if (!i_stall_ex) begin
                r_ex_slot <= i_bubble_ex ? '0 : w_id_slot;
            end
            // An abandoned access leaves MEM empty rather than re-requesting.
            if (i_clear_mem) begin
                r_mem_slot <= '0;
            end else if (!i_stall_mem) begin
                r_mem_slot <= w_ex_post;
            end
            r_wb_slot <= i_stall_mem ? '0 : r_mem_slot;
        end
    end

    assign o_fwd_a_sel = fwd_pick(r_ex_slot.rs1, r_mem_slot, r_wb_slot);
    assign o_fwd_b_sel = fwd_pick(r_ex_slot.rs2, r_mem_slot, r_wb_slot);
    assign o_mem_lsu   = r_mem_slot.lsu;
    assign o_load_use  = r_ex_slot.load && r_ex_slot.wren &&
                         ((r_ex_slot.rd == w_id_slot.rs1) || (r_ex_slot.rd == w_id_slot.rs2));

    // Opcode/funct bits and the WB access flag drive no decision here.
    assign w_unused = ^{i_id_inst[31:25], i_id_inst[14:12], i_id_inst[6:0], r_wb_slot.lsu};

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipeline_hazard_ctrl                                                 |
// | Stall/flush/forward sequencing and MEM handshake for 5-stage RV32I.  |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MAX_WAIT = 16
)
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_id_inst,
    input  logic        i_id_rd_wren,
    input  logic        i_id_lsu_rden,
    input  logic        i_id_lsu_wren,
    input  logic        i_ex_redirect,
    input  logic        i_lsu_ack,
    output logic        o_stall_if,
    output logic        o_stall_id,
    output logic        o_stall_ex,
    output logic        o_stall_mem,
    output logic        o_flush_id,
    output logic        o_flush_ex,
    output logic [1:0]  o_fwd_a_sel,
    output logic [1:0]  o_fwd_b_sel,
    output logic        o_lsu_req,
    output logic        o_lsu_timeout
);

    localparam int                 c_CNT_W    = $clog2(MAX_WAIT + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(MAX_WAIT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    ctrl_state_e        r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_timeout;

    logic w_mem_lsu;
    logic w_load_use;
    logic w_final;
    logic w_mem_stall;
    logic w_redirect;
    logic w_lu_stall;
    logic w_bubble_ex;

    hazard_scoreboard u_scoreboard (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_id_inst     (i_id_inst),
        .i_id_rd_wren  (i_id_rd_wren),
        .i_id_lsu_rden (i_id_lsu_rden),
        .i_id_lsu_wren (i_id_lsu_wren),
        .i_stall_ex    (o_stall_ex),
        .i_bubble_ex   (w_bubble_ex),
        .i_stall_mem   (o_stall_mem),
        .i_clear_mem   (w_final),
        .o_load_use    (w_load_use),
        .o_mem_lsu     (w_mem_lsu),
        .o_fwd_a_sel   (o_fwd_a_sel),
        .o_fwd_b_sel   (o_fwd_b_sel)
    );

    // Last un-acked cycle of a wait: release instead of stalling again.
    assign w_final     = (r_state == S_WAIT) && (r_cnt == c_CNT_LAST) && !i_lsu_ack;
    assign w_mem_stall = w_mem_lsu && !i_lsu_ack && !w_final;
    assign w_redirect  = i_ex_redirect && !w_mem_stall;
    assign w_lu_stall  = w_load_use && !i_ex_redirect && !w_mem_stall;

    assign o_stall_if  = w_mem_stall || w_lu_stall;
    assign o_stall_id  = w_mem_stall || w_lu_stall;
    assign o_stall_ex  = w_mem_stall;
    assign o_stall_mem = w_mem_stall;
    assign o_flush_id  = w_redirect;
    assign o_flush_ex  = w_redirect || w_lu_stall;
    assign w_bubble_ex = o_flush_ex || (o_stall_id && !o_stall_ex);

    assign o_lsu_req     = w_mem_lsu;
    assign o_lsu_timeout = r_timeout;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= S_RUN;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (w_mem_lsu && !i_lsu_ack) begin
                        r_state <= S_WAIT;
                        r_cnt   <= c_CNT_ONE;
                    end
                end
                S_WAIT: begin
                    if (i_lsu_ack) begin
                        r_state <= S_RUN;
                        r_cnt   <= '0;
                    end else if (w_final) begin
                        r_state   <= S_RUN;
                        r_cnt     <= '0;
                        r_timeout <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                default: begin
                    r_state <= S_RUN;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pipeline_hazard_ctrl                                              |
// | Directed self-checking bench for pipeline_hazard_ctrl (MAX_WAIT=4).  |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst;
    logic        rd_wren, lsu_rden, lsu_wren, redir, ack;
    logic        stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex;
    logic        lsu_req, lsu_timeout;
    logic [1:0]  fwd_a, fwd_b;
    int          checks = 0;
    int          errors = 0;

    wire [7:0] ov   = {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, lsu_req, lsu_timeout};
    wire [7:0] fwdv = {4'b0000, fwd_a, fwd_b};

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MAX_WAIT(4)) dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_id_inst     (inst),
        .i_id_rd_wren  (rd_wren),
        .i_id_lsu_rden (lsu_rden),
        .i_id_lsu_wren (lsu_wren),
        .i_ex_redirect (redir),
        .i_lsu_ack     (ack),
        .o_stall_if    (stall_if),
        .o_stall_id    (stall_id),
        .o_stall_ex    (stall_ex),
        .o_stall_mem   (stall_mem),
        .o_flush_id    (flush_id),
        .o_flush_ex    (flush_ex),
        .o_fwd_a_sel   (fwd_a),
        .o_fwd_b_sel   (fwd_b),
        .o_lsu_req     (lsu_req),
        .o_lsu_timeout (lsu_timeout)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic id(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                      input logic wr, input logic ld, input logic st);
        inst     = {7'd0, rs2, rs1, 3'd0, rd, 7'b0110011};
        rd_wren  = wr;
        lsu_rden = ld;
        lsu_wren = st;
    endtask

    task automatic nop();
        id(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ov bit order: stall_if stall_id stall_ex stall_mem flush_id flush_ex lsu_req lsu_timeout
    initial begin
        rst = 1'b1; redir = 1'b0; ack = 1'b0;
        nop();
        #7;
        chk("reset_outputs", ov, 8'h00);
        chk("reset_fwd", fwdv, 8'h00);
        #5 rst = 1'b0;
        tick();

        // Forwarding from EX/MEM, then MEM/WB, then MEM-over-WB priority
        id(0, 0, 5, 1, 0, 0); tick();
        id(5, 1, 7, 1, 0, 0); #2 chk("fwd_none", fwdv, 8'h00); tick();
        nop(); #2 chk("fwd_mem_a", fwdv, 8'b0000_0100); tick();
        id(0, 0, 8, 1, 0, 0); tick();
        nop(); tick();
        id(3, 8, 9, 1, 0, 0); tick();
        nop(); #2 chk("fwd_wb_b", fwdv, 8'b0000_0010); tick();
        id(0, 0, 10, 1, 0, 0); tick();
        id(0, 0, 10, 1, 0, 0); tick();
        id(10, 10, 15, 1, 0, 0); tick();
        nop(); #2 chk("fwd_mem_prio", fwdv, 8'b0000_0101); tick();

        // x0 never forwards or hazards
        id(0, 0, 0, 1, 0, 0); tick();
        id(0, 0, 17, 1, 0, 0); tick();
        nop(); #2 chk("fwd_x0", fwdv, 8'h00); chk("x0_no_stall", ov, 8'h00); tick();
        id(0, 0, 0, 1, 1, 0); tick();
        id(0, 0, 18, 1, 0, 0); #2 chk("lu_x0", ov, 8'h00); tick();
        nop(); ack = 1'b1; #2 chk("ack_first_cycle", ov, 8'b0000_0010); tick();
        ack = 1'b0;

        // Load-use on rs2
        id(2, 0, 6, 1, 1, 0); tick();
        id(1, 6, 11, 1, 0, 0); #2 chk("lu_stall", ov, 8'b1100_0100); tick();
        ack = 1'b1; #2 chk("lu_release", ov, 8'b0000_0010); chk("lu_bubble_fwd", fwdv, 8'h00); tick();
        ack = 1'b0;
        nop(); #2 chk("lu_fwd_wb", fwdv, 8'b0000_0010); chk("lu_no_more", ov, 8'h00); tick();

        // Redirect overrides load-use
        id(2, 0, 12, 1, 1, 0); tick();
        id(12, 0, 19, 1, 0, 0); redir = 1'b1; #2 chk("redir_over_lu", ov, 8'b0000_1100); tick();
        redir = 1'b0;
        nop(); ack = 1'b1; #2 chk("redir_lsu", ov, 8'b0000_0010); tick();
        ack = 1'b0;

        // Store wait: ack in cycle 4 coincides with the final cycle, ack wins
        id(3, 4, 0, 0, 0, 1); tick();
        nop(); tick();
        redir = 1'b1;
        #2 chk("wait_c1", ov, 8'b1111_0010); tick();
        #2 chk("wait_c2", ov, 8'b1111_0010); tick();
        #2 chk("wait_c3", ov, 8'b1111_0010); tick();
        ack = 1'b1; #2 chk("wait_ack_release", ov, 8'b0000_1110); tick();
        ack = 1'b0; redir = 1'b0;
        #2 chk("wait_done", ov, 8'h00); tick();

        // Timeout with no ack
        id(5, 0, 13, 1, 1, 0); tick();
        nop(); tick();
        #2 chk("to_c1", ov, 8'b1111_0010); tick();
        #2 chk("to_c2", ov, 8'b1111_0010); tick();
        #2 chk("to_c3", ov, 8'b1111_0010); tick();
        #2 chk("to_release", ov, 8'b0000_0010); tick();
        #2 chk("to_sticky", ov, 8'b0000_0001); tick();
        #2 chk("to_sticky2", ov, 8'b0000_0001);
        #1 rst = 1'b1;
        #1 chk("to_reset_clear", ov, 8'h00);
        rst = 1'b0;
        tick();

        // Asynchronous reset in the middle of a wait
        id(3, 4, 0, 0, 0, 1); tick();
        nop(); tick();
        #2 chk("rw_c1", ov, 8'b1111_0010); tick();
        #2 chk("rw_c2", ov, 8'b1111_0010);
        rst = 1'b1;
        #1 chk("rw_async", ov, 8'h00); chk("rw_async_fwd", fwdv, 8'h00);
        #3 rst = 1'b0;
        tick();
        #2 chk("rw_run", ov, 8'h00);
        id(3, 4, 0, 0, 0, 1); tick();
        nop(); tick();
        #2 chk("rw_again_c1", ov, 8'b1111_0010); tick();
        #2 chk("rw_again_c2", ov, 8'b1111_0010); tick();
        #2 chk("rw_again_c3", ov, 8'b1111_0010); tick();
        #2 chk("rw_again_release", ov, 8'b0000_0010); tick();
        #2 chk("rw_again_timeout", ov, 8'b0000_0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central hazard and sequencing controller for the 5-stage RV32I pipeline. Decides each cycle which pipeline registers hold, which receive a bubble, and which forwarding path feeds the EX operands. It also owns the data-memory request handshake for the MEM stage. It sits beside the decoder and keeps its own shadow scoreboard of the EX/MEM/WB stage destinations, so the datapath registers need not export them.

## Interface
- MAX_WAIT, default 16: maximum consecutive un-acked cycles of a MEM access before the controller abandons it. Legal range 2..255.
- i_clk  in  1  clock, rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_id_inst  in  32  instruction in ID: rs1 = [19:15], rs2 = [24:20], rd = [11:7]
- i_id_rd_wren, i_id_lsu_rden, i_id_lsu_wren  in  1 each  decoder control bits for the ID instruction
- i_ex_redirect  in  1  branch taken / jal / jalr resolved in EX; held stable by the datapath while EX is frozen
- i_lsu_ack  in  1  data memory completes the current access this cycle
- o_stall_if, o_stall_id, o_stall_ex, o_stall_mem  out  1 each  hold that stage's PC or pipeline register
- o_flush_id, o_flush_ex  out  1 each  load a bubble into IF/ID or ID/EX at the next edge
- o_fwd_a_sel, o_fwd_b_sel  out  2 each  EX operand source: 00 regfile, 01 EX/MEM result, 10 MEM/WB writeback
- o_lsu_req  out  1  MEM stage holds a load or store awaiting completion
- o_lsu_timeout  out  1  sticky flag: an access was abandoned

## Operation
- Shadow scoreboard, one slot each for EX, MEM and WB:
  - EX slot holds {rs1, rs2, rd, wren, load, lsu}; MEM and WB slots hold {rd, wren, lsu}.
  - Slots advance when their stage is not stalled. A flushed or stalled-upstream stage receives a bubble (all fields 0).
  - rd = x0 forces wren = 0. x0 never hazards and never forwards.
- Forwarding (per operand, EX slot rs1 / rs2):
  - EX/MEM result when MEM.wren and MEM.rd matches; else MEM/WB when WB.wren and WB.rd matches; else regfile.
  - MEM has priority over WB.
- Load-use: EX.load and EX.wren, and EX.rd equals an rs1 or rs2 of i_id_inst → o_stall_if = o_stall_id = 1, o_flush_ex = 1, for exactly one cycle.
- Redirect: i_ex_redirect → o_flush_id = o_flush_ex = 1. It overrides load-use, so no stall is issued in that cycle.
- Memory handshake:
  - o_lsu_req = MEM.lsu.
  - When o_lsu_req is high and i_lsu_ack is low, all four stall outputs are asserted and flushes are suppressed.
  - Ack in the first cycle costs zero stall.
- FSM states:
  - RUN: MEM.lsu and no ack → WAIT; counter = 1.
  - WAIT: on ack → RUN. With no ack the counter increments. The cycle in which counter == MAX_WAIT−1 and no ack arrives is the final cycle: stalls drop, the MEM slot is cleared at the edge, o_lsu_timeout is set, and the FSM → RUN.
- Priority: memory wait > redirect > load-use > forwarding.
- Reset (any time, including mid-WAIT):
  - FSM → RUN, counter = 0, scoreboard cleared, o_lsu_timeout = 0.
  - Consequently every output is 0 (fwd_sel = 00).

## Timing
- All outputs are combinational from registered state plus i_id_inst, i_ex_redirect and i_lsu_ack. There are no internal combinational loops.
- Load-use bubble: 1 cycle. Redirect penalty: 2 bubbles, both inserted at the same edge.
- Timeout: MAX_WAIT consecutive un-acked cycles, counted from the first request cycle, before release. o_lsu_timeout is visible from the following cycle.
- Simultaneous ack and timeout in the final cycle: the ack wins and o_lsu_timeout stays 0.
- A redirect that arrives during WAIT takes effect in the cycle the stall releases.

## Structure
- Shared package hazard_pkg:
  - fwd_sel_e {FWD_RF = 2'b00, FWD_MEM = 2'b01, FWD_WB = 2'b10}
  - ctrl_state_e {S_RUN, S_WAIT}
  - stage_slot_t struct
  - opcode constants OP_LOAD = 7'b0000011 and OP_STORE = 7'b0100011
- One sub-module, hazard_scoreboard: slot registers and forwarding compare. The FSM, counter and stall/flush logic live in the top module.

## Test plan
- Forwarding: add x5 followed directly by sub using x5 → o_fwd_a_sel = 01. With one instruction between them → 10. With rd = x0 → 00.
- Load-use: lw x6 in EX, ID uses rs2 = x6 → one cycle of o_stall_if/o_stall_id/o_flush_ex = 1, then o_fwd_b_sel = 10 and no further stall.
- Redirect: i_ex_redirect with a load-use condition in the same cycle → o_flush_id = o_flush_ex = 1 and o_stall_id = 0.
- Memory wait: sw in MEM with ack after 3 cycles → o_lsu_req high for 4 cycles, all stalls high for 3, o_lsu_timeout = 0.
- Timeout: MAX_WAIT = 4, ack never arrives → stalls high for cycles 1–3, released in cycle 4, o_lsu_timeout = 1 from cycle 5. A later i_reset pulse clears it.
- Reset during WAIT: assert i_reset asynchronously mid-cycle → all outputs 0 immediately and the FSM in RUN after release.
